// File: rtl/ldpc_pkg.sv
// Shared constants, state encoding and base-matrix entry helpers for the QC-LDPC encoder.
package ldpc_pkg;
    localparam int data_w = 8;
    localparam int R      = 24;
    localparam int C      = 12;
    localparam int D      = 24;
    localparam int K      = R - C;
    localparam int RW     = $clog2(C);

    localparam logic [data_w-1:0] NULL_ENTRY = 8'hFF;

    typedef enum logic [1:0] {IDLE, LAMBDA, PARITY, DONE} state_t;

    // An all-ones entry marks an all-zero circulant block.
    function automatic logic entry_is_null(input logic [data_w-1:0] e);
        return e == NULL_ENTRY;
    endfunction

    // Circulant shift amount carried by a base-matrix entry.
    function automatic logic [data_w-1:0] entry_shift(input logic [data_w-1:0] e);
        return e % data_w'(D);
    endfunction
endpackage

// File: rtl/qc_shift.sv
// Circular block shift y[k] = x[(k+s) % D]; a null entry yields the zero block.
module qc_shift
    import ldpc_pkg::*;
(
    input  logic [D-1:0]      x_i,
    input  logic [data_w-1:0] e_i,
    output logic [D-1:0]      y_o
);
    logic [2*D-1:0]    xx;
    logic [data_w-1:0] s;

    // Doubling the vector turns the rotation into a plain right shift.
    always_comb begin
        s   = entry_shift(e_i);
        xx  = {x_i, x_i} >> s;
        y_o = entry_is_null(e_i) ? '0 : xx[D-1:0];
    end
endmodule

// File: rtl/ldpc_qc_encoder.sv
// Systematic dual-diagonal QC-LDPC encoder: serial row sums, then parity recursion.
module ldpc_qc_encoder
    import ldpc_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [K*D-1:0]          msg_i,
    input  logic [C*R*data_w-1:0]   mtx_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [R*D-1:0]          cw_o
);
    state_t            state_q;
    logic [RW-1:0]     r_q;
    logic [D-1:0]      acc_q;
    logic [D-1:0]      lambda_q [C];
    logic [D-1:0]      p_q [C];
    logic [K*D-1:0]    msg_q;
    logic [R*D-1:0]    cw_q;
    logic              busy_q, done_q, err_q;

    logic [data_w-1:0] row_e [K];
    logic [data_w-1:0] col_e [C];
    logic [D-1:0]      term [K];
    logic [D-1:0]      lambda_d;
    logic [D-1:0]      p0_shift;
    logic [D-1:0]      p_d;
    logic [R*D-1:0]    cw_d;
    logic [RW-1:0]     m_d;
    logic              m_found, m_multi, err_d;

    // Entries of the current block row (info columns) and of the first parity column.
    always_comb begin
        for (int j = 0; j < K; j++) row_e[j] = mtx_i[(int'(r_q)*R + j)*data_w +: data_w];
        for (int i = 0; i < C; i++) col_e[i] = mtx_i[(i*R + K)*data_w +: data_w];
    end

    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_lam
            qc_shift u_sh (.x_i(msg_q[gi*D +: D]), .e_i(row_e[gi]), .y_o(term[gi]));
        end
        for (genvar gi = 0; gi < C; gi++) begin : g_cw
            assign cw_d[(K+gi)*D +: D] = p_q[gi];
        end
    endgenerate
    assign cw_d[K*D-1:0] = msg_q;

    qc_shift u_px (.x_i(p_q[0]), .e_i(col_e[0]), .y_o(p0_shift));

    // Row sum of the shifted information blocks for row r.
    always_comb begin
        lambda_d = '0;
        for (int j = 0; j < K; j++) lambda_d = lambda_d ^ term[j];
    end

    // Locate the single middle entry of the first parity column and validate its shape.
    always_comb begin
        m_d     = '0;
        m_found = 1'b0;
        m_multi = 1'b0;
        for (int i = 1; i <= C-2; i++) begin
            if (!entry_is_null(col_e[i])) begin
                if (m_found) m_multi = 1'b1;
                else begin
                    m_found = 1'b1;
                    m_d     = RW'(i);
                end
            end
        end
        err_d = entry_is_null(col_e[C-1]) ||
                (entry_shift(col_e[C-1]) != entry_shift(col_e[0])) ||
                !m_found || m_multi;
    end

    // Parity block for row r from the dual-diagonal recursion.
    always_comb begin
        if (r_q == '0) begin
            p_d = acc_q;
        end else if (r_q == RW'(1)) begin
            p_d = lambda_q[0] ^ p0_shift;
        end else begin
            p_d = p_q[r_q - RW'(1)] ^ lambda_q[r_q - RW'(1)];
            if (m_found && ((r_q - RW'(1)) == m_d)) p_d = p_d ^ p_q[0];
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            r_q     <= '0;
            acc_q   <= '0;
            msg_q   <= '0;
            cw_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < C; i++) begin
                lambda_q[i] <= '0;
                p_q[i]      <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= LAMBDA;
                        busy_q  <= 1'b1;
                        r_q     <= '0;
                        acc_q   <= '0;
                        msg_q   <= msg_i;
                    end
                end
                LAMBDA: begin
                    lambda_q[r_q] <= lambda_d;
                    acc_q         <= acc_q ^ lambda_d;
                    if (r_q == RW'(C-1)) begin
                        state_q <= PARITY;
                        r_q     <= '0;
                    end else begin
                        r_q <= r_q + RW'(1);
                    end
                end
                PARITY: begin
                    p_q[r_q] <= p_d;
                    if (r_q == RW'(C-1)) begin
                        state_q <= DONE;
                        r_q     <= '0;
                    end else begin
                        r_q <= r_q + RW'(1);
                    end
                end
                DONE: begin
                    cw_q    <= cw_d;
                    done_q  <= 1'b1;
                    err_q   <= err_d;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;
    assign cw_o   = cw_q;
endmodule

// File: tb/tb_ldpc_qc_encoder.sv
// Directed and randomised checks of ldpc_qc_encoder against a golden encoder and H*cw^T.
module tb_ldpc_qc_encoder;
    import ldpc_pkg::*;

    logic                  clk, rst, start;
    logic [K*D-1:0]        msg;
    logic [C*R*data_w-1:0] mtx;
    logic                  busy, done, err;
    logic [R*D-1:0]        cw;

    logic [C*R*data_w-1:0] mtx_good, mtx_bad;
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [K*D-1:0] msg;
        bit             bad_mtx;
        bit             exp_err;
        bit             exp_zero;
    } vec_t;
    vec_t vecs [7];

    // 802.16e rate-1/2 base matrix, -1 marks a null block.
    int base [12][24] = '{
        '{-1,94,73,-1,-1,-1,-1,-1,55,83,-1,-1, 7, 0,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1},
        '{-1,27,-1,-1,-1,22,79, 9,-1,-1,-1,12,-1, 0, 0,-1,-1,-1,-1,-1,-1,-1,-1,-1},
        '{-1,-1,-1,24,22,81,-1,33,-1,-1,-1, 0,-1,-1, 0, 0,-1,-1,-1,-1,-1,-1,-1,-1},
        '{61,-1,47,-1,-1,-1,-1,-1,65,25,-1,-1,-1,-1,-1, 0, 0,-1,-1,-1,-1,-1,-1,-1},
        '{-1,-1,39,-1,-1,-1,84,-1,-1,41,72,-1,-1,-1,-1,-1, 0, 0,-1,-1,-1,-1,-1,-1},
        '{-1,-1,-1,-1,46,40,-1,82,-1,-1,-1,79, 0,-1,-1,-1,-1, 0, 0,-1,-1,-1,-1,-1},
        '{-1,-1,95,53,-1,-1,-1,-1,-1,14,18,-1,-1,-1,-1,-1,-1,-1, 0, 0,-1,-1,-1,-1},
        '{-1,11,73,-1,-1,-1, 2,-1,-1,47,-1,-1,-1,-1,-1,-1,-1,-1,-1, 0, 0,-1,-1,-1},
        '{12,-1,-1,-1,83,24,-1,43,-1,-1,-1,51,-1,-1,-1,-1,-1,-1,-1,-1, 0, 0,-1,-1},
        '{-1,-1,-1,-1,-1,94,-1,59,-1,-1,70,72,-1,-1,-1,-1,-1,-1,-1,-1,-1, 0, 0,-1},
        '{-1,-1, 7,65,-1,-1,-1,-1,39,49,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1, 0, 0},
        '{43,-1,-1,-1,-1,66,-1,41,-1,-1,-1,26, 7,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1, 0}
    };

    ldpc_qc_encoder dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .msg_i(msg), .mtx_i(mtx),
        .busy_o(busy), .done_o(done), .err_o(err), .cw_o(cw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ent(input logic [C*R*data_w-1:0] h, input int i, input int j);
        return h[(i*R + j)*data_w +: data_w];
    endfunction

    function automatic logic [D-1:0] tb_shift(input logic [D-1:0] x, input logic [7:0] e);
        logic [D-1:0] y;
        int s;
        y = '0;
        if (e != 8'hFF) begin
            s = int'(e) % D;
            for (int k = 0; k < D; k++) y[k] = x[(k + s) % D];
        end
        return y;
    endfunction

    function automatic logic [R*D-1:0] golden(input logic [K*D-1:0] m, input logic [C*R*data_w-1:0] h);
        logic [D-1:0] lam [C];
        logic [D-1:0] p [C];
        logic [D-1:0] acc;
        logic [R*D-1:0] c;
        int mrow;
        acc = '0;
        for (int i = 0; i < C; i++) begin
            lam[i] = '0;
            for (int j = 0; j < K; j++) lam[i] ^= tb_shift(m[j*D +: D], ent(h, i, j));
            acc ^= lam[i];
        end
        mrow = -1;
        for (int i = C-2; i >= 1; i--) if (ent(h, i, K) != 8'hFF) mrow = i;
        p[0] = acc;
        p[1] = lam[0] ^ tb_shift(p[0], ent(h, 0, K));
        for (int r = 2; r < C; r++) begin
            p[r] = p[r-1] ^ lam[r-1];
            if (r-1 == mrow) p[r] ^= p[0];
        end
        c[K*D-1:0] = m;
        for (int i = 0; i < C; i++) c[(K+i)*D +: D] = p[i];
        return c;
    endfunction

    function automatic bit syn_ok(input logic [R*D-1:0] c, input logic [C*R*data_w-1:0] h);
        logic [D-1:0] s;
        for (int i = 0; i < C; i++) begin
            s = '0;
            for (int j = 0; j < R; j++) s ^= tb_shift(c[j*D +: D], ent(h, i, j));
            if (s != '0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [R*D-1:0] act, input logic [R*D-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic rand_msg(output logic [K*D-1:0] m);
        for (int w = 0; w < K*D/32; w++) m[w*32 +: 32] = $urandom;
    endtask

    // Pulse start, then wait (bounded) for done; lat = cycles after the accepting edge, -1 on timeout.
    task automatic run_encode(input logic [K*D-1:0] m, input logic [C*R*data_w-1:0] h, output int lat);
        msg   = m;
        mtx   = h;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
    endtask

    initial begin
        int lat, n_done, first, busy_bad;
        logic [K*D-1:0] m;
        logic [R*D-1:0] exp_cw;

        for (int i = 0; i < C; i++)
            for (int j = 0; j < R; j++)
                mtx_good[(i*R + j)*data_w +: data_w] = (base[i][j] < 0) ? 8'hFF : 8'(base[i][j]);
        mtx_bad = mtx_good;
        mtx_bad[((C-1)*R + K)*data_w +: data_w] = 8'd8;

        vecs[0].msg = '0;                       vecs[0].bad_mtx = 0; vecs[0].exp_err = 0; vecs[0].exp_zero = 1;
        vecs[1].msg = 288'd1;                   vecs[1].bad_mtx = 0; vecs[1].exp_err = 0; vecs[1].exp_zero = 0;
        vecs[2].msg = '1;                       vecs[2].bad_mtx = 0; vecs[2].exp_err = 0; vecs[2].exp_zero = 0;
        vecs[3].msg = {9{32'hA5C3_0F1E}};       vecs[3].bad_mtx = 0; vecs[3].exp_err = 0; vecs[3].exp_zero = 0;
        vecs[4].msg = '0; vecs[4].msg[K*D-1] = 1'b1;
                                                vecs[4].bad_mtx = 0; vecs[4].exp_err = 0; vecs[4].exp_zero = 0;
        vecs[5].msg = {9{32'h1357_9BDF}};       vecs[5].bad_mtx = 1; vecs[5].exp_err = 1; vecs[5].exp_zero = 0;
        vecs[6].msg = 288'd1;                   vecs[6].bad_mtx = 0; vecs[6].exp_err = 0; vecs[6].exp_zero = 0;

        rst = 1'b1; start = 1'b0; msg = '0; mtx = mtx_good;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_busy", R*D'(busy), '0);
        chk("reset_done", R*D'(done), '0);
        chk("reset_err",  R*D'(err),  '0);
        chk("reset_cw",   cw,         '0);
        $display("reset: busy=%0b done=%0b err=%0b", busy, done, err);

        // Directed table.
        for (int v = 0; v < 7; v++) begin
            run_encode(vecs[v].msg, vecs[v].bad_mtx ? mtx_bad : mtx_good, lat);
            exp_cw = golden(vecs[v].msg, vecs[v].bad_mtx ? mtx_bad : mtx_good);
            $display("vec %0d: latency=%0d err=%0b", v, lat, err);
            chk($sformatf("vec%0d_latency", v), R*D'(lat), R*D'(25));
            chk($sformatf("vec%0d_busy_at_done", v), R*D'(busy), '0);
            chk($sformatf("vec%0d_err", v), R*D'(err), R*D'(vecs[v].exp_err));
            chk($sformatf("vec%0d_cw", v), cw, exp_cw);
            chk($sformatf("vec%0d_systematic", v), R*D'(cw[K*D-1:0]), R*D'(vecs[v].msg));
            if (!vecs[v].bad_mtx) chk($sformatf("vec%0d_syndrome", v), R*D'(syn_ok(cw, mtx_good)), R*D'(1));
            if (vecs[v].exp_zero) chk($sformatf("vec%0d_zero_cw", v), cw, '0);
        end

        // Back-to-back random encodes: start re-asserted in the done cycle.
        for (int n = 0; n < 100; n++) begin
            rand_msg(m);
            run_encode(m, mtx_good, lat);
            $display("rand %0d: latency=%0d", n, lat);
            chk($sformatf("rand%0d_latency", n), R*D'(lat), R*D'(25));
            chk($sformatf("rand%0d_cw", n), cw, golden(m, mtx_good));
        end

        // Extra start pulses while busy are ignored.
        rand_msg(m);
        msg = m; mtx = mtx_good; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0; first = -1; busy_bad = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                if (first < 0) first = cyc;
            end
            if (first < 0 && !busy) busy_bad++;
            start = (cyc == 3 || cyc == 10);
        end
        start = 1'b0;
        $display("restart: dones=%0d first=%0d busy_drops=%0d", n_done, first, busy_bad);
        chk("restart_done_count", R*D'(n_done), R*D'(1));
        chk("restart_done_cycle", R*D'(first), R*D'(25));
        chk("restart_busy_held", R*D'(busy_bad), '0);
        chk("restart_cw", cw, golden(m, mtx_good));

        // Mid-encode reset after an err=1 encode.
        run_encode({9{32'h0F0F_3C3C}}, mtx_bad, lat);
        chk("pre_reset_err", R*D'(err), R*D'(1));
        rand_msg(m);
        msg = m; mtx = mtx_good; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        $display("midreset: busy=%0b done=%0b err=%0b", busy, done, err);
        chk("midreset_busy", R*D'(busy), '0);
        chk("midreset_cw",   cw,         '0);
        chk("midreset_err",  R*D'(err),  '0);
        #3 rst = 1'b0;
        n_done = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        chk("midreset_no_done", R*D'(n_done), '0);
        run_encode(m, mtx_good, lat);
        $display("post-reset: latency=%0d err=%0b", lat, err);
        chk("postreset_latency", R*D'(lat), R*D'(25));
        chk("postreset_cw", cw, golden(m, mtx_good));
        chk("postreset_err", R*D'(err), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
